// File: rtl/washer_pkg.sv
// Shared washer encodings: FSM state codes and timer phase codes.
package washer_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'b000,
    S_FILL   = 3'b001,
    S_WASH   = 3'b010,
    S_RINSE  = 3'b011,
    S_SPIN   = 3'b100,
    S_PAUSED = 3'b101
  } state_e;

  localparam logic [2:0] PH_IDLE  = 3'b000;
  localparam logic [2:0] PH_FILL  = 3'b001;
  localparam logic [2:0] PH_WASH  = 3'b010;
  localparam logic [2:0] PH_RINSE = 3'b011;
  localparam logic [2:0] PH_SPIN  = 3'b100;

  // PAUSED keeps the spin code so the timer resumes the same phase
  function automatic logic [2:0] phase_of(state_e s);
    logic [2:0] ph;
    ph = PH_IDLE;
    case (s)
      S_FILL:   ph = PH_FILL;
      S_WASH:   ph = PH_WASH;
      S_RINSE:  ph = PH_RINSE;
      S_SPIN:   ph = PH_SPIN;
      S_PAUSED: ph = PH_SPIN;
      default:  ph = PH_IDLE;
    endcase
    return ph;
  endfunction

endpackage

// File: rtl/wash_cycle_fsm_if.sv
// Sequencer <-> panel/timer signal bundle.
interface wash_cycle_fsm_if;

  logic       Coin_In;
  logic       Double_Wash;
  logic       Pause_Req;
  logic       Time_Event;
  logic [2:0] Timer_Encoding;
  logic       Pause_Enable_T;
  logic       Wash_Done;
  logic [2:0] State_Out;

  modport master (
    output Coin_In, Double_Wash, Pause_Req, Time_Event,
    input  Timer_Encoding, Pause_Enable_T, Wash_Done, State_Out
  );

  modport slave (
    input  Coin_In, Double_Wash, Pause_Req, Time_Event,
    output Timer_Encoding, Pause_Enable_T, Wash_Done, State_Out
  );

endinterface

// File: rtl/wash_cycle_fsm_event_edge_det.sv
// Rising-edge detector for the timer's expiry pulse.
module event_edge_det (
  input  logic Clk,
  input  logic Rst,
  input  logic d,
  output logic pulse
);

  logic prev_q;

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) prev_q <= 1'b0;
    else      prev_q <= d;
  end

  assign pulse = d & ~prev_q;

endmodule

// File: rtl/wash_cycle_fsm.sv
// Washing-machine phase sequencer.
// Optional second wash+rinse pass: define WASH_DOUBLE_WASH_EN.
module wash_cycle_fsm (
  input  logic            Clk,
  input  logic            Rst,
  wash_cycle_fsm_if.slave bus
);

  import washer_pkg::*;

  state_e     state_q, state_d;
  logic       done_q, done_d;
  logic [2:0] enc_q, so_q;
  logic       pen_q;
  logic       te_edge, ev;
  logic       req_q, pass_q;

  event_edge_det u_edge (
    .Clk   (Clk),
    .Rst   (Rst),
    .d     (bus.Time_Event),
    .pulse (te_edge)
  );

  // a level held through a pause must not count once resumed
  assign ev = te_edge & (state_q != S_PAUSED);

`ifdef WASH_DOUBLE_WASH_EN
  logic req_d, pass_d;

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      req_q  <= 1'b0;
      pass_q <= 1'b0;
    end else begin
      req_q  <= req_d;
      pass_q <= pass_d;
    end
  end
`else
  assign req_q  = 1'b0;
  assign pass_q = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    done_d  = done_q;
`ifdef WASH_DOUBLE_WASH_EN
    req_d   = req_q;
    pass_d  = pass_q;
`endif
    case (state_q)
      S_IDLE: if (bus.Coin_In) begin
        state_d = S_FILL;
        done_d  = 1'b0;
`ifdef WASH_DOUBLE_WASH_EN
        req_d   = bus.Double_Wash;
        pass_d  = 1'b0;
`endif
      end
      S_FILL:  if (ev) state_d = S_WASH;
      S_WASH:  if (ev) state_d = S_RINSE;
      S_RINSE: if (ev) begin
        if (req_q && !pass_q) begin
          state_d = S_WASH;
`ifdef WASH_DOUBLE_WASH_EN
          pass_d  = 1'b1;
`endif
        end else begin
          state_d = S_SPIN;
        end
      end
      S_SPIN: begin
        if (bus.Pause_Req) begin
          state_d = S_PAUSED;
        end else if (ev) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      S_PAUSED: if (!bus.Pause_Req) state_d = S_SPIN;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state_q <= S_IDLE;
      done_q  <= 1'b0;
      enc_q   <= PH_IDLE;
      pen_q   <= 1'b1;
      so_q    <= 3'b000;
    end else begin
      state_q <= state_d;
      done_q  <= done_d;
      enc_q   <= phase_of(state_d);
      pen_q   <= (state_d == S_IDLE) || (state_d == S_PAUSED);
      so_q    <= state_d;
    end
  end

  assign bus.Timer_Encoding = enc_q;
  assign bus.Pause_Enable_T = pen_q;
  assign bus.Wash_Done      = done_q;
  assign bus.State_Out      = so_q;

endmodule

// File: tb/tb_wash_cycle_fsm.sv
// Scoreboard bench for wash_cycle_fsm with a phase-plan reference model.
module tb_wash_cycle_fsm;

`ifdef WASH_DOUBLE_WASH_EN
  localparam bit DW_EN = 1'b1;
`else
  localparam bit DW_EN = 1'b0;
`endif

  logic Clk = 1'b0;
  logic Rst = 1'b0;

  wash_cycle_fsm_if bus ();

  wash_cycle_fsm dut (
    .Clk (Clk),
    .Rst (Rst),
    .bus (bus)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic [2:0] st;
    logic [2:0] enc;
    logic       pen;
    logic       done;
  } exp_t;

  exp_t sb[$];
  exp_t got;
  int   vectors = 0;
  int   errors  = 0;

  // reference: remaining phases of the running cycle, front = current
  logic [2:0] plan[$];
  bit m_paused, m_done, m_prev;

  function automatic exp_t expect_now();
    exp_t e;
    bit idle;
    idle   = (plan.size() == 0);
    e.st   = idle ? 3'd0 : (m_paused ? 3'd5 : plan[0]);
    e.enc  = idle ? 3'd0 : plan[0];
    e.pen  = idle || m_paused;
    e.done = m_done;
    return e;
  endfunction

  task automatic compare(input string name, input exp_t e);
    vectors++;
    if (bus.State_Out !== e.st || bus.Timer_Encoding !== e.enc ||
        bus.Pause_Enable_T !== e.pen || bus.Wash_Done !== e.done) begin
      errors++;
      $display("FAIL %s t=%0t got st=%b enc=%b pen=%b done=%b want st=%b enc=%b pen=%b done=%b",
               name, $time, bus.State_Out, bus.Timer_Encoding,
               bus.Pause_Enable_T, bus.Wash_Done, e.st, e.enc, e.pen, e.done);
    end
  endtask

  task automatic model_reset();
    plan.delete();
    m_paused = 0;
    m_done   = 0;
    m_prev   = 0;
  endtask

  task automatic step(input bit c, input bit dw, input bit p, input bit te);
    bit ev;
    bus.Coin_In     = c;
    bus.Double_Wash = dw;
    bus.Pause_Req   = p;
    bus.Time_Event  = te;
    ev = te && !m_prev && !m_paused;
    if (plan.size() == 0) begin
      if (c) begin
        plan = '{3'd1, 3'd2, 3'd3};
        if (DW_EN && dw) begin
          plan.push_back(3'd2);
          plan.push_back(3'd3);
        end
        plan.push_back(3'd4);
        m_done = 0;
      end
    end else if (m_paused) begin
      if (!p) m_paused = 0;
    end else if (plan[0] == 3'd4 && p) begin
      m_paused = 1;
    end else if (ev) begin
      void'(plan.pop_front());
      if (plan.size() == 0) m_done = 1;
    end
    m_prev = te;
    sb.push_back(expect_now());
    @(posedge Clk);
    @(negedge Clk);
  endtask

  task automatic pulse_n(input int n);
    for (int i = 0; i < n; i++) begin
      step(0, 0, 0, 1);
      step(0, 0, 0, 0);
    end
  endtask

  task automatic reset_now(input bit coin);
    Rst         = 1'b0;
    bus.Coin_In = coin;
    #1;
    model_reset();
    compare("reset", expect_now());
    @(posedge Clk);
    @(negedge Clk);
    compare("reset_hold", expect_now());
    Rst = 1'b1;
  endtask

  always @(posedge Clk) begin
    #1;
    if (sb.size() > 0) begin
      got = sb.pop_front();
      compare("scoreboard", got);
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    bus.Coin_In     = 1'b1;
    bus.Double_Wash = 1'b0;
    bus.Pause_Req   = 1'b0;
    bus.Time_Event  = 1'b0;
    model_reset();
    @(negedge Clk);
    reset_now(1'b1);

    // coin held through reset, then a single cycle
    step(1, 0, 0, 0);
    step(0, 0, 0, 0);
    pulse_n(4);
    step(0, 0, 0, 0);

    // double-wash request at coin
    step(1, 1, 0, 0);
    pulse_n(6);
    step(0, 0, 0, 0);

    // pause in SPIN with the event level held throughout
    step(1, 0, 0, 0);
    pulse_n(3);
    step(0, 0, 1, 1);
    for (int i = 0; i < 19; i++) step(0, 0, 1, 1);
    for (int i = 0; i < 4; i++) step(0, 0, 0, 1);
    step(0, 0, 0, 0);
    step(0, 0, 0, 1);
    step(0, 0, 0, 0);

    // pause in WASH ignored, coin in RINSE ignored
    step(1, 0, 0, 0);
    pulse_n(1);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 0);
    step(0, 0, 1, 1);
    step(1, 0, 0, 0);
    step(1, 1, 0, 0);

    // reset while in RINSE, then restart
    reset_now(1'b0);
    step(0, 0, 0, 0);
    step(1, 0, 0, 0);
    pulse_n(4);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 7) == 0, $urandom_range(0, 1) == 1,
           $urandom_range(0, 5) == 0, $urandom_range(0, 2) == 0);
      if ($urandom_range(0, 499) == 0) begin
        @(posedge Clk);
        #2;
        reset_now($urandom_range(0, 1) == 1);
      end
    end

    @(posedge Clk);
    #2;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL drain pending=%0d want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule

// File: doc/wash_cycle_fsm.md
# wash_cycle_fsm

Top-level washing-machine sequencer. It consumes the one-cycle `Time_Event` pulse produced by the neighbouring phase timer and steps through the fill, wash, rinse and spin phases. It drives the timer's `Timer_Encoding` and `Pause_Enable_T` inputs, and reports cycle completion to the front panel. It sits directly beside the timer: its outputs feed the timer and the timer's output feeds it.

## Interface
Parameters:
- none; all encodings are fixed constants in the shared package.

Ports:
- `Clk`  in  1  system clock.
- `Rst`  in  1  reset; asynchronous, active-low.
- `Coin_In`  in  1  level/pulse; starts a cycle when seen high in IDLE.
- `Double_Wash`  in  1  request for a second wash+rinse pass; sampled only on coin acceptance.
- `Pause_Req`  in  1  level; pause request, honoured only in SPIN.
- `Time_Event`  in  1  phase-expiry pulse from the timer.
- `Timer_Encoding`  out  3  phase code to the timer.
- `Pause_Enable_T`  out  1  freezes the timer.
- `Wash_Done`  out  1  high after a completed cycle, until the next coin.
- `State_Out`  out  3  current state code, for the panel and debug.

## Operation
- States: IDLE=000, FILL=001, WASH=010, RINSE=011, SPIN=100, PAUSED=101.
- Phase codes on `Timer_Encoding`: IDLE 000, FILL 001, WASH 010, RINSE 011, SPIN 100.
  - PAUSED keeps 100.
- Expiry qualifier `ev` is true only when all three hold:
  - `Time_Event`=1,
  - the registered previous `Time_Event`=0 (rising edge),
  - the state is not PAUSED.
  - Reason: the timer holds `Time_Event` unchanged while paused, so a level can persist. A level held across a pause must never advance two phases.
- IDLE:
  - `Coin_In`=1 → go to FILL, clear `Wash_Done`, latch `second_pass_req` = `Double_Wash` (macro dependent), clear `pass_cnt`.
- FILL: on `ev` → WASH.
- WASH: on `ev` → RINSE.
- RINSE: on `ev`:
  - if `second_pass_req` and `pass_cnt`=0 → set `pass_cnt`=1 and go to WASH;
  - otherwise → SPIN.
- SPIN:
  - `Pause_Req`=1 → PAUSED. This has priority over `ev` in the same cycle; that event is lost and the following one is awaited.
  - Otherwise, on `ev` → IDLE and set `Wash_Done`=1.
- PAUSED: `Pause_Req`=0 → SPIN. No event is consumed while in PAUSED.
- `Pause_Req` is ignored in all states other than SPIN.
- `Coin_In` is ignored in all states other than IDLE.
- `Pause_Enable_T` = 1 in IDLE and PAUSED, 0 otherwise. The timer is therefore frozen between cycles.
- Illegal state codes (110, 111) → IDLE on the next clock; `Wash_Done` unchanged.
- `pass_cnt` is 1 bit; it never wraps past 1.

## Timing
- All outputs are registered. `Timer_Encoding`, `Pause_Enable_T` and `State_Out` are decoded from the next state, so they change on the same edge as the state.
- Reset values:
  - state IDLE; `Timer_Encoding`=000; `Pause_Enable_T`=1; `Wash_Done`=0; `State_Out`=000;
  - previous-event register 0; `second_pass_req`=0; `pass_cnt`=0.
- Latency:
  - `Coin_In` high at edge N → FILL with `Pause_Enable_T`=0 visible after edge N.
  - `Time_Event` high in cycle N → new phase after edge N (1-cycle response).
- `Pause_Req` rising → `Pause_Enable_T`=1 after the next edge, so the timer freezes one cycle later.
- Reset asserted mid-cycle → immediate return to IDLE; `Wash_Done` cleared; the latched double-wash request is lost.

## Configuration
- Macro: `WASH_DOUBLE_WASH_EN`.
- Defined:
  - `Double_Wash` is latched at coin acceptance;
  - the RINSE→WASH second pass is implemented;
  - worst-case cycle is 6 phase expiries (FILL, WASH, RINSE, WASH, RINSE, SPIN).
- Undefined:
  - `Double_Wash` is unused and `second_pass_req` is tied to 0;
  - `pass_cnt` logic is removed;
  - RINSE always goes to SPIN;
  - the port is still present for a stable pinout.

## Structure
- Shared package `washer_pkg` holds:
  - the state enum/localparams (3-bit codes above);
  - the phase-code constants `PH_IDLE`, `PH_FILL`, `PH_WASH`, `PH_RINSE`, `PH_SPIN`, shared with the timer's encoding decode.
- Sub-module `event_edge_det`: one register plus AND gate, with async active-low reset. It produces the edge pulse from `Time_Event`. The PAUSED gate stays in the FSM.
- Next-state logic and output registers live in the top module.

## Test plan
- Reset with `Coin_In`=1 held → all outputs at reset values; after deassertion, FILL one edge later with `Timer_Encoding`=001 and `Pause_Enable_T`=0.
- Single cycle: coin, then 4 single-cycle `Time_Event` pulses → `Timer_Encoding` sequence 001, 010, 011, 100, 000; `Wash_Done`=1 after the 4th pulse.
- With the macro defined and `Double_Wash`=1 at coin → sequence 001, 010, 011, 010, 011, 100, 000 over 6 pulses.
- Without the macro, same stimulus → 4-phase sequence only.
- In SPIN, `Pause_Req`=1 for 20 cycles with `Time_Event` held high throughout → stays PAUSED with `Pause_Enable_T`=1. After release: no advance while `Time_Event` stays high; advances to IDLE only on the next fresh 0→1 event.
- `Pause_Req`=1 during WASH → ignored, `Pause_Enable_T`=0. Coin pulse during RINSE → no effect.
- Reset pulsed while in RINSE → IDLE, `Wash_Done`=0. A new coin restarts at FILL.
